// File: rtl/trigger_conditioner.sv
// trigger_conditioner: multi-channel trigger front end.
// Each channel synchronises its asynchronous input, detects a rising or
// falling edge, stretches it to a programmable gate, applies hold-off and
// keeps a saturating count of accepted triggers.
// Optional build macro TRIG_COND_COINC_EN adds a coincidence output
// (trigger_coinc) that compares the number of enabled active channels
// against coinc_thr.
module trigger_conditioner #(
  parameter int N_CH        = 4,
  parameter int WIDTH_W     = 10,
  parameter int SYNC_STAGES = 3,
  parameter int CNT_W       = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_CH-1:0]         trig_in,
  input  logic [N_CH-1:0]         enable_trigger,
  input  logic [N_CH-1:0]         edge_sel,
  input  logic                    retrig_mode,
  input  logic [WIDTH_W-1:0]      trigger_width,
  input  logic [WIDTH_W-1:0]      holdoff,
  input  logic                    cnt_clr,
`ifdef TRIG_COND_COINC_EN
  input  logic [$clog2(N_CH+1)-1:0] coinc_thr,
  output logic                    trigger_coinc,
`endif
  output logic [N_CH-1:0]         trigger,
  output logic                    trigger_any,
  output logic [N_CH*CNT_W-1:0]   trig_cnt
);

  typedef enum logic [1:0] {IDLE, ACTIVE, HOLDOFF} state_e;

  // Gate length reload value; a zero width still produces a one-cycle gate.
  logic [WIDTH_W-1:0] width_eff;
  logic [WIDTH_W-1:0] width_load;
  assign width_eff  = (trigger_width == '0) ? WIDTH_W'(1) : trigger_width;
  assign width_load = width_eff - WIDTH_W'(1);

  logic [N_CH-1:0] trigger_d, trigger_q;
  logic [N_CH-1:0] active_vec;
  logic            trigger_any_d, trigger_any_q;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    // sync_q[SYNC_STAGES] is the history flop used for edge detection.
    logic [SYNC_STAGES:0] sync_q, sync_d;
    state_e               state_q, state_d;
    logic [WIDTH_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH_W-1:0]   hold_q, hold_d;
    logic [CNT_W-1:0]     acc_q, acc_d;
    logic                 edge_det;
    logic                 accept;

    // Synchroniser shift and edge detection on the two oldest samples.
    always_comb begin
      sync_d   = {sync_q[SYNC_STAGES-1:0], trig_in[g]};
      edge_det = edge_sel[g] ? (~sync_q[SYNC_STAGES-1] &  sync_q[SYNC_STAGES])
                             : ( sync_q[SYNC_STAGES-1] & ~sync_q[SYNC_STAGES]);
    end

    // Next-state logic: gate / hold-off sequencing and edge acceptance.
    always_comb begin
      // NOTE: every output of a combinational block gets a default first so
      // no path leaves it unassigned, which would otherwise infer a latch.
      state_d = state_q;
      cnt_d   = cnt_q;
      hold_d  = hold_q;
      accept  = 1'b0;
      if (!enable_trigger[g]) begin
        state_d = IDLE;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (edge_det) begin
              state_d = ACTIVE;
              cnt_d   = width_load;
              hold_d  = holdoff;
              accept  = 1'b1;
            end
          end
          ACTIVE: begin
            if (edge_det && retrig_mode) begin
              cnt_d  = width_load;
              hold_d = holdoff;
              accept = 1'b1;
            end else if (cnt_q == '0) begin
              if (hold_q == '0) begin
                state_d = IDLE;
              end else begin
                state_d = HOLDOFF;
                cnt_d   = hold_q - WIDTH_W'(1);
              end
            end else begin
              cnt_d = cnt_q - WIDTH_W'(1);
            end
          end
          HOLDOFF: begin
            if (cnt_q == '0) state_d = IDLE;
            else             cnt_d   = cnt_q - WIDTH_W'(1);
          end
          default: state_d = IDLE;
        endcase
      end
    end

    // Output logic: gate open when disabled, otherwise high while ACTIVE.
    always_comb begin
      trigger_d[g]  = ~enable_trigger[g] | (state_d == ACTIVE);
      active_vec[g] = (state_q == ACTIVE);
    end

    // Saturating accepted-trigger counter; clear wins unless an edge lands.
    always_comb begin
      if (cnt_clr)                   acc_d = {{(CNT_W-1){1'b0}}, accept};
      else if (accept && ~&acc_q)    acc_d = acc_q + CNT_W'(1);
      else                           acc_d = acc_q;
    end

    // State register for synchroniser, FSM, gate counter and trigger count.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_q  <= '0;
        state_q <= IDLE;
        cnt_q   <= '0;
        hold_q  <= '0;
        acc_q   <= '0;
      end else begin
        // NOTE: registers take non-blocking assignments so every flop samples
        // values from before the clock edge, independent of statement order.
        sync_q  <= sync_d;
        state_q <= state_d;
        cnt_q   <= cnt_d;
        hold_q  <= hold_d;
        acc_q   <= acc_d;
      end
    end

    assign trig_cnt[g*CNT_W +: CNT_W] = acc_q;
  end

  assign trigger_any_d = |(trigger_d & enable_trigger);

  // Registered trigger outputs and their enabled OR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trigger_q     <= '0;
      trigger_any_q <= 1'b0;
    end else begin
      trigger_q     <= trigger_d;
      trigger_any_q <= trigger_any_d;
    end
  end

  assign trigger     = trigger_q;
  assign trigger_any = trigger_any_q;

`ifdef TRIG_COND_COINC_EN
  localparam int POP_W = $clog2(N_CH+1);
  logic [POP_W-1:0] pop_cnt;
  logic             coinc_d, coinc_q;

  // Count enabled active channels and compare against the threshold.
  always_comb begin
    pop_cnt = '0;
    for (int i = 0; i < N_CH; i++) begin
      pop_cnt = pop_cnt + POP_W'(active_vec[i] & enable_trigger[i]);
    end
    coinc_d = (coinc_thr != '0) && (pop_cnt >= coinc_thr);
  end

  // Coincidence flag, one cycle behind the trigger bits it is built from.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) coinc_q <= 1'b0;
    else        coinc_q <= coinc_d;
  end

  assign trigger_coinc = coinc_q;
`endif

endmodule

// File: tb/tb_trigger_conditioner.sv
// Self-checking bench for trigger_conditioner: directed scenarios with
// literal expectations, then randomized stimulus against a cycle model.
module tb_trigger_conditioner;
  localparam int N_CH    = 4;
  localparam int WIDTH_W = 10;
  localparam int S       = 3;
  localparam int CNT_W   = 4;
  localparam int CMAX    = (1 << CNT_W) - 1;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [N_CH-1:0]       trig_in, enable_trigger, edge_sel;
  logic                  retrig_mode, cnt_clr;
  logic [WIDTH_W-1:0]    trigger_width, holdoff;
  logic [N_CH-1:0]       trigger;
  logic                  trigger_any;
  logic [N_CH*CNT_W-1:0] trig_cnt;
`ifdef TRIG_COND_COINC_EN
  logic [2:0]            coinc_thr;
  logic                  trigger_coinc;
`endif

  int n_checks = 0;
  int n_errors = 0;
  bit chk_on   = 0;

  trigger_conditioner #(.N_CH(N_CH), .WIDTH_W(WIDTH_W), .SYNC_STAGES(S), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .trig_in(trig_in), .enable_trigger(enable_trigger),
    .edge_sel(edge_sel), .retrig_mode(retrig_mode), .trigger_width(trigger_width),
    .holdoff(holdoff), .cnt_clr(cnt_clr),
`ifdef TRIG_COND_COINC_EN
    .coinc_thr(coinc_thr), .trigger_coinc(trigger_coinc),
`endif
    .trigger(trigger), .trigger_any(trigger_any), .trig_cnt(trig_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 idle, 1 gate high, 2 hold-off. left = gate cycles still to come.
  bit hist [N_CH][S+1];
  int mode [N_CH];
  int left [N_CH];
  int hleft[N_CH];
  int hlat [N_CH];
  int mcnt [N_CH];
  bit mtrig[N_CH];
  bit many;
  bit mcoinc;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      for (int c = 0; c < N_CH; c++) begin
        for (int j = 0; j <= S; j++) hist[c][j] = 0;
        mode[c] = 0; left[c] = 0; hleft[c] = 0; hlat[c] = 0; mcnt[c] = 0; mtrig[c] = 0;
      end
      many = 0; mcoinc = 0;
    end else begin
      int wp, pop;
      wp  = (trigger_width == 0) ? 1 : int'(trigger_width);
      pop = 0;
      for (int c = 0; c < N_CH; c++) if (mode[c] == 1 && enable_trigger[c]) pop++;
`ifdef TRIG_COND_COINC_EN
      mcoinc = (coinc_thr != 0) && (pop >= int'(coinc_thr));
`endif
      many = 0;
      for (int c = 0; c < N_CH; c++) begin
        bit newer, older, ed, acc;
        newer = hist[c][S-1];
        older = hist[c][S];
        ed    = edge_sel[c] ? (!newer && older) : (newer && !older);
        acc   = 0;
        if (!enable_trigger[c]) begin
          mode[c] = 0;
        end else if (mode[c] == 0) begin
          if (ed) begin mode[c] = 1; left[c] = wp; hlat[c] = int'(holdoff); acc = 1; end
        end else if (mode[c] == 1) begin
          if (ed && retrig_mode) begin
            left[c] = wp; hlat[c] = int'(holdoff); acc = 1;
          end else begin
            left[c]--;
            if (left[c] == 0) begin
              if (hlat[c] == 0) mode[c] = 0;
              else begin mode[c] = 2; hleft[c] = hlat[c]; end
            end
          end
        end else begin
          hleft[c]--;
          if (hleft[c] == 0) mode[c] = 0;
        end
        if (cnt_clr)                   mcnt[c] = acc ? 1 : 0;
        else if (acc && mcnt[c] < CMAX) mcnt[c]++;
        mtrig[c] = !enable_trigger[c] || (mode[c] == 1);
        if (mtrig[c] && enable_trigger[c]) many = 1;
        for (int j = S; j > 0; j--) hist[c][j] = hist[c][j-1];
        hist[c][0] = trig_in[c];
      end
    end
  end

  // Compare process: outputs against the model on every falling edge.
  initial forever begin
    @(negedge clk);
    if (chk_on && rst_n) begin
      logic [N_CH-1:0]       et;
      logic [N_CH*CNT_W-1:0] ec;
      for (int c = 0; c < N_CH; c++) begin
        et[c] = mtrig[c];
        ec[c*CNT_W +: CNT_W] = CNT_W'(mcnt[c]);
      end
      check("trigger", 64'(trigger), 64'(et));
      check("trigger_any", 64'(trigger_any), 64'(many));
      check("trig_cnt", 64'(trig_cnt), 64'(ec));
`ifdef TRIG_COND_COINC_EN
      check("trigger_coinc", 64'(trigger_coinc), 64'(mcoinc));
`endif
    end
  end

  // ---------------- directed helpers ----------------
  function automatic int cnt_of(input int ch);
    return int'(trig_cnt[ch*CNT_W +: CNT_W]);
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic clr_counts();
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
  endtask

  // Drive trig_in[ch] high for 'hold' cycles from each start time (-1 = unused);
  // cycle c is the value sampled at clock edge c. Reports the first edge at
  // which trigger[ch] is seen high and the number of high cycles.
  task automatic drive_measure(input int ch, input int ta, input int tb, input int tc,
                               input int hold, input int ncyc,
                               output int rise, output int len);
    rise = -1; len = 0;
    for (int c = 0; c < ncyc; c++) begin
      trig_in[ch] = (c >= ta && c < ta + hold) ||
                    (tb >= 0 && c >= tb && c < tb + hold) ||
                    (tc >= 0 && c >= tc && c < tc + hold);
      @(negedge clk);
      if (trigger[ch]) begin
        if (rise < 0) rise = c;
        len++;
      end
    end
    trig_in[ch] = 1'b0;
  endtask

  initial begin
    int rise, len;
    rst_n = 1'b0; trig_in = '0; enable_trigger = '1; edge_sel = '0;
    retrig_mode = 1'b0; cnt_clr = 1'b0; trigger_width = 10'd10; holdoff = '0;
`ifdef TRIG_COND_COINC_EN
    coinc_thr = 3'd2;
`endif
    #23;
    check("reset_trigger", 64'(trigger), 64'd0);
    check("reset_any", 64'(trigger_any), 64'd0);
    check("reset_cnt", 64'(trig_cnt), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk_on = 1'b1;
    idle(2);

    // 1: basic 10-cycle gate, input held high.
    drive_measure(0, 0, -1, -1, 40, 50, rise, len);
    check("t1_rise_edge", 64'(rise), 64'd3);
    check("t1_len", 64'(len), 64'd10);
    check("t1_cnt", 64'(cnt_of(0)), 64'd1);
    idle(5);

    // 2: width 0 gives one cycle, width 1023 gives 1023 cycles.
    clr_counts();
    trigger_width = 10'd0;
    drive_measure(0, 0, -1, -1, 2, 10, rise, len);
    check("t2_w0_len", 64'(len), 64'd1);
    check("t2_w0_cnt", 64'(cnt_of(0)), 64'd1);
    trigger_width = 10'd1023;
    drive_measure(0, 0, -1, -1, 2, 1040, rise, len);
    check("t2_w1023_len", 64'(len), 64'd1023);
    check("t2_w1023_cnt", 64'(cnt_of(0)), 64'd2);
    idle(5);

    // 3: hold-off swallows the edge at t=10, accepts t=30.
    clr_counts();
    trigger_width = 10'd5; holdoff = 10'd20;
    drive_measure(0, 0, 10, 30, 2, 60, rise, len);
    check("t3_len", 64'(len), 64'd10);
    check("t3_cnt", 64'(cnt_of(0)), 64'd2);
    idle(30);

    // 4: second edge 4 cycles in, without and with retrigger.
    holdoff = '0; trigger_width = 10'd8;
    clr_counts();
    drive_measure(2, 0, 4, -1, 2, 25, rise, len);
    check("t4_noretrig_len", 64'(len), 64'd8);
    check("t4_noretrig_cnt", 64'(cnt_of(2)), 64'd1);
    idle(5);
    retrig_mode = 1'b1;
    clr_counts();
    drive_measure(2, 0, 4, -1, 2, 25, rise, len);
    check("t4_retrig_len", 64'(len), 64'd12);
    check("t4_retrig_cnt", 64'(cnt_of(2)), 64'd2);
    retrig_mode = 1'b0;
    idle(5);

    // 5: disable ch1 mid-gate, edges while disabled, re-enable.
    trigger_width = 10'd10;
    clr_counts();
    trig_in[1] = 1'b1;
    idle(5);
    enable_trigger[1] = 1'b0;
    @(negedge clk);
    check("t5_disabled_open", 64'(trigger[1]), 64'd1);
    trig_in[1] = 1'b0; idle(4);
    trig_in[1] = 1'b1; idle(8);
    check("t5_disabled_still_open", 64'(trigger[1]), 64'd1);
    check("t5_disabled_nocount", 64'(cnt_of(1)), 64'd1);
    enable_trigger[1] = 1'b1;
    @(negedge clk);
    check("t5_reenabled_low", 64'(trigger[1]), 64'd0);
    idle(6);
    check("t5_no_spurious", 64'(trigger[1]), 64'd0);
    trig_in[1] = 1'b0;
    idle(4);

    // 5b: asynchronous reset in the middle of a gate.
    trig_in[0] = 1'b1;
    idle(6);
    trig_in[0] = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("t5_async_trigger", 64'(trigger), 64'd0);
    check("t5_async_any", 64'(trigger_any), 64'd0);
    check("t5_async_cnt", 64'(trig_cnt), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);

    // 6: saturation at 15, then clear coinciding with an accepted edge.
    trigger_width = 10'd1;
    for (int p = 0; p < 20; p++) drive_measure(0, 0, -1, -1, 2, 5, rise, len);
    check("t6_saturated", 64'(cnt_of(0)), 64'd15);
    idle(3);
    trig_in[0] = 1'b1;
    idle(3);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    check("t6_clr_with_edge", 64'(cnt_of(0)), 64'd1);
    trig_in[0] = 1'b0;
    idle(5);

    // Randomized phase against the model.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      for (int c = 0; c < N_CH; c++)
        if ($urandom_range(3) == 0) trig_in[c] = ~trig_in[c];
      if ($urandom_range(49) == 0) enable_trigger = N_CH'($urandom);
      if ($urandom_range(99) == 0) edge_sel = N_CH'($urandom);
      if ($urandom_range(29) == 0) retrig_mode = 1'($urandom);
      if ($urandom_range(39) == 0) trigger_width = WIDTH_W'($urandom_range(12));
      if ($urandom_range(39) == 0) holdoff = WIDTH_W'($urandom_range(10));
      cnt_clr = ($urandom_range(99) == 0);
`ifdef TRIG_COND_COINC_EN
      if ($urandom_range(99) == 0) coinc_thr = 3'($urandom_range(4));
`endif
      @(negedge clk);
    end
    cnt_clr = 1'b0;
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Hard time bound so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
